rggen_apb_command_master: RTL and testbench
===========================================

# rggen_apb_command_master

Single-outstanding APB4 requester that turns a valid/ready command stream (from a host bridge, debug port or test sequencer) into APB transfers on the bus feeding the generated register blocks such as `block_1`. It sequences the SETUP and ACCESS phases and bounds each ACCESS with a programmable timeout. It returns read data and completion status on a buffered valid/ready response channel.

## Interface
Parameters:
- ADDRESS_WIDTH, 7, width of command address and PADDR
- BUS_WIDTH, 32, APB data width (32 or 64); strobe width is BUS_WIDTH/8
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles per transfer; 0 disables the timeout

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_address  in  ADDRESS_WIDTH  byte address
- i_cmd_write_data  in  BUS_WIDTH  write data
- i_cmd_strobe  in  BUS_WIDTH/8  byte enables for writes
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed when high with o_rsp_valid
- o_rsp_read_data  out  BUS_WIDTH  PRDATA for reads; 0 for writes and timeouts
- o_rsp_status  out  2  2'b00 OKAY, 2'b10 SLVERR, 2'b11 TIMEOUT
- o_psel, o_penable, o_pwrite  out  1 each  APB control
- o_paddr  out  ADDRESS_WIDTH  APB address
- o_pprot  out  3  constant 3'b000
- o_pstrb  out  BUS_WIDTH/8  APB strobe
- o_pwdata  out  BUS_WIDTH  APB write data
- i_pready, i_pslverr  in  1 each  APB completion and error
- i_prdata  in  BUS_WIDTH  APB read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESPONSE. Reset state is IDLE.
- IDLE
  - o_cmd_ready = 1; it is 0 in every other state.
  - On i_cmd_valid, capture the command into registers and go to SETUP.
- SETUP
  - o_psel = 1, o_penable = 0.
  - Always advances to ACCESS after one cycle.
- ACCESS
  - o_psel = 1, o_penable = 1.
  - i_pready = 1 completes the transfer:
    - capture i_prdata for reads, or 0 for writes;
    - status = i_pslverr ? SLVERR : OKAY;
    - go to RESPONSE.
- Timeout
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with i_pready = 0. Width is clog2(TIMEOUT_CYCLES+1).
  - If TIMEOUT_CYCLES ≠ 0, i_pready = 0 and count == TIMEOUT_CYCLES−1: end the transfer with status TIMEOUT, read data 0, and go to RESPONSE.
  - i_pready = 1 on that same cycle takes priority and completes normally.
- RESPONSE
  - o_psel = o_penable = 0; o_rsp_valid = 1.
  - Response fields are held stable until i_rsp_ready = 1, then return to IDLE.
- Address alignment: o_paddr = captured address with the low clog2(BUS_WIDTH/8) bits forced to 0.
- Strobe: o_pstrb = captured strobe for writes, all-zero for reads.
- Write data: o_pwdata = captured write data for writes, 0 for reads.
- Held APB signals: o_paddr, o_pwrite, o_pstrb and o_pwdata are registered and stay constant from SETUP through the last ACCESS cycle. In IDLE and RESPONSE they keep their last values.
- i_pslverr and i_prdata are ignored unless i_pready = 1 in ACCESS.

## Timing
- Reset values: FSM IDLE; o_psel = o_penable = o_pwrite = 0; o_paddr = o_pstrb = o_pwdata = 0; o_rsp_valid = 0; o_rsp_read_data = 0; o_rsp_status = 0; timeout counter 0. o_cmd_ready = 1 in the first cycle after reset.
- Reset mid-transfer (any state): the in-flight transfer is dropped, no response is produced, and all outputs return to reset values after the reset edge.
- Cycle numbering, with the command handshake in cycle 0:
  - SETUP (psel = 1) in cycle 1.
  - ACCESS (penable = 1) from cycle 2.
  - Zero-wait slave (i_pready = 1 in cycle 2): o_rsp_valid = 1 in cycle 3.
  - With i_rsp_ready held high: IDLE in cycle 4, o_cmd_ready = 1 in cycle 4.
- Throughput: one transfer per 4 cycles maximum; single outstanding transfer.
- o_cmd_ready and o_rsp_valid are decoded from state only, never combinationally from i_cmd_valid or i_rsp_ready.
- o_psel never deasserts during ACCESS before completion or timeout; o_penable is 1 only in ACCESS.

## Test plan
- Write: cmd addr 7'h40, data 32'hA5A5_1234, strobe 4'hF; slave pready in first ACCESS cycle → paddr 7'h40, pwrite 1, pstrb 4'hF, psel high cycles 1–2, penable high cycle 2 only; response status 2'b00, read data 0 in cycle 3.
- Read with 3 wait states: cmd addr 7'h04, read; pready high in the 4th ACCESS cycle with prdata 32'hDEAD_BEEF → pstrb 0, pwdata 0, response status 00, read data 32'hDEADBEEF, o_rsp_valid in cycle 6.
- Error and alignment: cmd addr 7'h13 (unaligned), pready with pslverr = 1 → paddr 7'h10, status 2'b10.
- Timeout: TIMEOUT_CYCLES = 4, pready held 0 → exactly 4 ACCESS cycles, then psel = 0, status 2'b11, read data 0. A second run with pready = 1 on the 4th ACCESS cycle completes with status 00.
- Response backpressure: hold i_rsp_ready = 0 for 5 cycles after a completed read → rsp fields stable, o_cmd_ready = 0, i_cmd_valid ignored; the new command is accepted only after the response handshake.
- Reset mid-transfer: assert i_rst during the 2nd ACCESS cycle → next cycle psel = penable = 0, rsp_valid = 0, cmd_ready = 1 after release, no response ever emitted for the dropped command.

Source files
------------

// File: rtl/rggen_apb_command_master.sv
// Single-outstanding APB4 requester: valid/ready command in, APB transfer out,
// buffered valid/ready response back, with an optional ACCESS-phase timeout.
module rggen_apb_command_master #(
  parameter int ADDRESS_WIDTH  = 7,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output logic [1:0]               o_rsp_status,
  output logic                     o_psel,
  output logic                     o_penable,
  output logic                     o_pwrite,
  output logic [ADDRESS_WIDTH-1:0] o_paddr,
  output logic [2:0]               o_pprot,
  output logic [BUS_WIDTH/8-1:0]   o_pstrb,
  output logic [BUS_WIDTH-1:0]     o_pwdata,
  input  logic                     i_pready,
  input  logic                     i_pslverr,
  input  logic [BUS_WIDTH-1:0]     i_prdata
);

  localparam int STRB_WIDTH  = BUS_WIDTH / 8;
  localparam int ADDR_LSB    = $clog2(STRB_WIDTH);
  localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK   = ADDRESS_WIDTH'((1 << ADDR_LSB) - 1);
  localparam logic [COUNT_WIDTH-1:0]   TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] STATUS_OKAY    = 2'b00;
  localparam logic [1:0] STATUS_SLVERR  = 2'b10;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESPONSE
  } state_e;

  state_e                   state;
  state_e                   state_next;
  logic [COUNT_WIDTH-1:0]   timeout_count;
  logic                     cmd_accept;
  logic                     access_done;
  logic                     timeout_hit;

  assign cmd_accept  = (state == IDLE) && i_cmd_valid;
  assign access_done = (state == ACCESS) && i_pready;
  // A ready slave on the final allowed cycle wins over the timeout.
  assign timeout_hit = TIMEOUT_EN && (state == ACCESS) && !i_pready &&
                       (timeout_count == TIMEOUT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_cmd_valid) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (access_done || timeout_hit) begin
          state_next = RESPONSE;
        end
      end
      RESPONSE: begin
        if (i_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    o_cmd_ready = (state == IDLE);
    o_psel      = (state == SETUP) || (state == ACCESS);
    o_penable   = (state == ACCESS);
    o_rsp_valid = (state == RESPONSE);
    o_pprot     = 3'b000;
  end

  // Bus request fields are captured once at the handshake and held for the whole transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_paddr  <= '0;
      o_pwrite <= 1'b0;
      o_pstrb  <= '0;
      o_pwdata <= '0;
    end else if (cmd_accept) begin
      o_paddr  <= i_cmd_address & ~ALIGN_MASK;
      o_pwrite <= i_cmd_write;
      o_pstrb  <= i_cmd_write ? i_cmd_strobe : {STRB_WIDTH{1'b0}};
      o_pwdata <= i_cmd_write ? i_cmd_write_data : {BUS_WIDTH{1'b0}};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timeout_count <= '0;
    end else if (state == SETUP) begin
      timeout_count <= '0;
    end else if ((state == ACCESS) && !i_pready) begin
      timeout_count <= timeout_count + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_read_data <= '0;
      o_rsp_status    <= STATUS_OKAY;
    end else if (access_done) begin
      o_rsp_read_data <= o_pwrite ? {BUS_WIDTH{1'b0}} : i_prdata;
      o_rsp_status    <= i_pslverr ? STATUS_SLVERR : STATUS_OKAY;
    end else if (timeout_hit) begin
      o_rsp_read_data <= '0;
      o_rsp_status    <= STATUS_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_rggen_apb_command_master.sv
// Directed bench for rggen_apb_command_master: cycle-accurate checks of APB phases,
// responses, timeout, backpressure and mid-transfer reset.
module tb_rggen_apb_command_master;

  localparam int AW = 7;
  localparam int BW = 32;
  localparam int SW = BW / 8;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_address;
  logic [BW-1:0] cmd_write_data;
  logic [SW-1:0] cmd_strobe;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [BW-1:0] rsp_read_data;
  logic [1:0]    rsp_status;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic [SW-1:0] pstrb;
  logic [BW-1:0] pwdata;
  logic          pready;
  logic          pslverr;
  logic [BW-1:0] prdata;

  int errors = 0;
  int checks = 0;

  rggen_apb_command_master #(
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_write      (cmd_write),
    .i_cmd_address    (cmd_address),
    .i_cmd_write_data (cmd_write_data),
    .i_cmd_strobe     (cmd_strobe),
    .o_rsp_valid      (rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_read_data  (rsp_read_data),
    .o_rsp_status     (rsp_status),
    .o_psel           (psel),
    .o_penable        (penable),
    .o_pwrite         (pwrite),
    .o_paddr          (paddr),
    .o_pprot          (pprot),
    .o_pstrb          (pstrb),
    .o_pwdata         (pwdata),
    .i_pready         (pready),
    .i_pslverr        (pslverr),
    .i_prdata         (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr,
                           input logic [BW-1:0] data, input logic [SW-1:0] strb);
    cmd_valid      = 1'b1;
    cmd_write      = wr;
    cmd_address    = addr;
    cmd_write_data = data;
    cmd_strobe     = strb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({psel, penable, pwrite, rsp_valid} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got psel/pen/pwrite/rspv=%b want 0000",
               {psel, penable, pwrite, rsp_valid});
    end
    checks++;
    if (paddr !== '0 || pstrb !== '0 || pwdata !== '0 || pprot !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_bus: got paddr=%h pstrb=%h pwdata=%h pprot=%b want all 0",
               paddr, pstrb, pwdata, pprot);
    end
    checks++;
    if (rsp_read_data !== '0 || rsp_status !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_rsp: got rdata=%h status=%b want 0/00", rsp_read_data, rsp_status);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    // cycle 0: handshake
    issue_cmd(1'b1, 7'h40, 32'hA5A5_1234, 4'hF);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wr_cmd_ready: got %b want 1", cmd_ready);
    end
    tick();
    // cycle 1: SETUP
    cmd_valid = 1'b0;
    pready    = 1'b1;
    checks++;
    if ({psel, penable} !== 2'b10 || paddr !== 7'h40 || pwrite !== 1'b1 ||
        pstrb !== 4'hF || pwdata !== 32'hA5A5_1234) begin
      errors++;
      $display("[TB] FAIL wr_setup: got psel/pen=%b paddr=%h pwrite=%b pstrb=%h pwdata=%h want 10/40/1/f/a5a51234",
               {psel, penable}, paddr, pwrite, pstrb, pwdata);
    end
    tick();
    // cycle 2: ACCESS, zero wait
    checks++;
    if ({psel, penable} !== 2'b11 || cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_access: got psel/pen=%b cmd_ready=%b want 11/0", {psel, penable}, cmd_ready);
    end
    tick();
    // cycle 3: RESPONSE
    pready = 1'b0;
    checks++;
    if ({psel, penable} !== 2'b00 || rsp_valid !== 1'b1 || rsp_status !== 2'b00 ||
        rsp_read_data !== '0) begin
      errors++;
      $display("[TB] FAIL wr_response: got psel/pen=%b rspv=%b status=%b rdata=%h want 00/1/00/0",
               {psel, penable}, rsp_valid, rsp_status, rsp_read_data);
    end
    tick();
    // cycle 4: back in IDLE
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_idle: got cmd_ready=%b rspv=%b want 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_read_wait_states();
    issue_cmd(1'b0, 7'h04, 32'hFFFF_FFFF, 4'hF);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (pwrite !== 1'b0 || pstrb !== 4'h0 || pwdata !== '0 || paddr !== 7'h04) begin
      errors++;
      $display("[TB] FAIL rd_setup: got pwrite=%b pstrb=%h pwdata=%h paddr=%h want 0/0/0/04",
               pwrite, pstrb, pwdata, paddr);
    end
    // Wait states with garbage on the unqualified slave inputs.
    pready  = 1'b0;
    pslverr = 1'b1;
    prdata  = 32'h1111_1111;
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++;
      if ({psel, penable} !== 2'b11 || rsp_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rd_wait_c%0d: got psel/pen=%b rspv=%b want 11/0", c, {psel, penable}, rsp_valid);
      end
    end
    tick();
    // cycle 5: fourth ACCESS cycle completes (also the last cycle before timeout)
    pready  = 1'b1;
    pslverr = 1'b0;
    prdata  = 32'hDEAD_BEEF;
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL rd_access4: got psel/pen=%b want 11", {psel, penable});
    end
    tick();
    // cycle 6: RESPONSE
    pready = 1'b0;
    prdata = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_read_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL rd_response: got rspv=%b status=%b rdata=%h want 1/00/deadbeef",
               rsp_valid, rsp_status, rsp_read_data);
    end
    tick();
  endtask

  task automatic test_error_alignment();
    issue_cmd(1'b1, 7'h13, 32'h0000_00AB, 4'h3);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (paddr !== 7'h10 || pstrb !== 4'h3) begin
      errors++;
      $display("[TB] FAIL err_align: got paddr=%h pstrb=%h want 10/3", paddr, pstrb);
    end
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'h5555_AAAA;
    tick();
    tick();
    pready  = 1'b0;
    pslverr = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_read_data !== '0) begin
      errors++;
      $display("[TB] FAIL err_status: got rspv=%b status=%b rdata=%h want 1/10/0",
               rsp_valid, rsp_status, rsp_read_data);
    end
    tick();
  endtask

  task automatic test_timeout();
    issue_cmd(1'b0, 7'h08, '0, '0);
    pready = 1'b0;
    prdata = 32'hCAFE_F00D;
    tick();
    cmd_valid = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      checks++;
      if ({psel, penable} !== 2'b11) begin
        errors++;
        $display("[TB] FAIL to_access_c%0d: got psel/pen=%b want 11", c, {psel, penable});
      end
    end
    tick();
    checks++;
    if ({psel, penable} !== 2'b00 || rsp_valid !== 1'b1 || rsp_status !== 2'b11 ||
        rsp_read_data !== '0) begin
      errors++;
      $display("[TB] FAIL to_response: got psel/pen=%b rspv=%b status=%b rdata=%h want 00/1/11/0",
               {psel, penable}, rsp_valid, rsp_status, rsp_read_data);
    end
    prdata = '0;
    tick();
  endtask

  task automatic test_backpressure();
    issue_cmd(1'b0, 7'h0C, '0, '0);
    tick();
    cmd_valid = 1'b0;
    pready    = 1'b1;
    prdata    = 32'h1234_5678;
    tick();
    tick();
    // cycle 3: RESPONSE, consumer stalls with a new command waiting
    pready    = 1'b0;
    prdata    = '0;
    rsp_ready = 1'b0;
    issue_cmd(1'b1, 7'h20, 32'h0BAD_CAFE, 4'hC);
    for (int c = 3; c <= 7; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_read_data !== 32'h1234_5678 || rsp_status !== 2'b00 ||
          cmd_ready !== 1'b0 || psel !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold_c%0d: got rspv=%b rdata=%h status=%b cmd_ready=%b psel=%b want 1/12345678/00/0/0",
                 c, rsp_valid, rsp_read_data, rsp_status, cmd_ready, psel);
      end
      tick();
    end
    // cycle 8: release the response
    rsp_ready = 1'b1;
    tick();
    // cycle 9: IDLE, pending command accepted now
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: got cmd_ready=%b rspv=%b want 1/0", cmd_ready, rsp_valid);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (psel !== 1'b1 || paddr !== 7'h20 || pwrite !== 1'b1 || pstrb !== 4'hC ||
        pwdata !== 32'h0BAD_CAFE) begin
      errors++;
      $display("[TB] FAIL bp_next_setup: got psel=%b paddr=%h pwrite=%b pstrb=%h pwdata=%h want 1/20/1/c/0badcafe",
               psel, paddr, pwrite, pstrb, pwdata);
    end
    pready = 1'b1;
    tick();
    tick();
    pready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_read_data !== '0) begin
      errors++;
      $display("[TB] FAIL bp_next_rsp: got rspv=%b status=%b rdata=%h want 1/00/0",
               rsp_valid, rsp_status, rsp_read_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    int seen_rsp;
    issue_cmd(1'b1, 7'h2C, 32'h7777_7777, 4'hF);
    pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    // cycle 2: first ACCESS
    tick();
    // cycle 3: second ACCESS, reset lands at the end of it
    rst = 1'b1;
    checks++;
    if (penable !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_pre: got penable=%b want 1", penable);
    end
    tick();
    rst = 1'b0;
    checks++;
    if ({psel, penable, rsp_valid} !== 3'b000 || paddr !== '0 || pwrite !== 1'b0 ||
        pwdata !== '0 || pstrb !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got psel/pen/rspv=%b paddr=%h pwrite=%b pwdata=%h pstrb=%h want 000/0/0/0/0",
               {psel, penable, rsp_valid}, paddr, pwrite, pwdata, pstrb);
    end
    pready   = 1'b1;
    seen_rsp = 0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_cmd_ready: got %b want 1", cmd_ready);
    end
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid === 1'b1 || psel === 1'b1) seen_rsp++;
      tick();
    end
    pready = 1'b0;
    checks++;
    if (seen_rsp !== 0) begin
      errors++;
      $display("[TB] FAIL mid_no_rsp: got %0d active cycles want 0", seen_rsp);
    end
  endtask

  initial begin
    rst            = 1'b0;
    cmd_valid      = 1'b0;
    cmd_write      = 1'b0;
    cmd_address    = '0;
    cmd_write_data = '0;
    cmd_strobe     = '0;
    rsp_ready      = 1'b1;
    pready         = 1'b0;
    pslverr        = 1'b0;
    prdata         = '0;
    test_reset();
    test_write();
    test_read_wait_states();
    test_error_alignment();
    test_timeout();
    test_backpressure();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
